uart_core_ctrl: RTL and testbench

- Host-side sequencer for the CoreUART instance (UART_CORE). Converts a valid/ready byte stream into CoreUART write strobes, buffered in a small TX FIFO.
- Drains received bytes with CoreUART read strobes into a valid/ready RX output.
- Latches sticky error flags and drives the static configuration pins (BAUD_VAL, BIT8, PARITY_EN, ODD_N_EVEN) from a host-loaded register.

---
 rtl/uart_core_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_core_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_ctrl.sv
// uart_core_ctrl: host-side sequencer for a CoreUART instance.
//   Host TX : tx_data/tx_valid/tx_ready  -> TX FIFO -> CoreUART write strobes
//   Host RX : rx_data/rx_valid/rx_ready  <- CoreUART read strobes
//   Config  : cfg_load/cfg_* -> BAUD_VAL, BIT8, PARITY_EN, ODD_N_EVEN
//   Errors  : err_clr, err_status = {framing, parity, overflow}, sticky
//   CoreUART: CSN/WEN/OEN (active low), DATA_IN, DATA_OUT,
//             TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW
module uart_core_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int WR_GUARD = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        cfg_load,
  input  logic [12:0] cfg_baud,
  input  logic        cfg_bit8,
  input  logic        cfg_par_en,
  input  logic        cfg_odd,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic        err_clr,
  output logic [2:0]  err_status,
  output logic [12:0] BAUD_VAL,
  output logic        BIT8,
  output logic        PARITY_EN,
  output logic        ODD_N_EVEN,
  output logic        CSN,
  output logic        WEN,
  output logic        OEN,
  output logic [7:0]  DATA_IN,
  input  logic [7:0]  DATA_OUT,
  input  logic        TXRDY,
  input  logic        RXRDY,
  input  logic        PARITY_ERR,
  input  logic        FRAMING_ERR,
  input  logic        OVERFLOW
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int GW    = (WR_GUARD < 2) ? 1 : $clog2(WR_GUARD);
  localparam logic [GW-1:0] GCNT_LAST = GW'((WR_GUARD > 0) ? WR_GUARD - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_GUARD, S_RD1, S_RD2} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_gcnt;
  logic [7:0]      r_mem [TX_DEPTH];
  logic [PTR_W:0]  r_wr_ptr;
  logic [PTR_W:0]  r_rd_ptr;
  logic            r_csn, r_wen, r_oen;
  logic [7:0]      r_data_in;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic [2:0]      r_err;
  logic [12:0]     r_baud;
  logic            r_bit8, r_par_en, r_odd;

  logic w_empty, w_full, w_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = tx_valid && !w_full;

  assign tx_ready   = !w_full;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign err_status = r_err;
  assign BAUD_VAL   = r_baud;
  assign BIT8       = r_bit8;
  assign PARITY_EN  = r_par_en;
  assign ODD_N_EVEN = r_odd;
  assign CSN        = r_csn;
  assign WEN        = r_wen;
  assign OEN        = r_oen;
  assign DATA_IN    = r_data_in;

  // FIFO storage needs no reset: the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= tx_data;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_wr_ptr <= '0;
    else if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
  end

  // Strobes are assigned on the edge that enters a state, so they are
  // registered and valid for the whole of WR / RD1 / RD2.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_gcnt     <= '0;
      r_rd_ptr   <= '0;
      r_csn      <= 1'b1;
      r_wen      <= 1'b1;
      r_oen      <= 1'b1;
      r_data_in  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (RXRDY && !r_rx_valid) begin
            r_state <= S_RD1;
            r_csn   <= 1'b0;
            r_oen   <= 1'b0;
          end else if (!w_empty && TXRDY) begin
            r_state   <= S_WR;
            r_csn     <= 1'b0;
            r_wen     <= 1'b0;
            r_data_in <= r_mem[r_rd_ptr[PTR_W-1:0]];
          end
        end
        S_WR: begin
          r_csn    <= 1'b1;
          r_wen    <= 1'b1;
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_gcnt   <= '0;
          r_state  <= (WR_GUARD == 0) ? S_IDLE : S_GUARD;
        end
        S_GUARD: begin
          if (r_gcnt == GCNT_LAST) r_state <= S_IDLE;
          else r_gcnt <= r_gcnt + 1'b1;
        end
        S_RD1: r_state <= S_RD2;
        S_RD2: begin
          r_csn      <= 1'b1;
          r_oen      <= 1'b1;
          r_rx_data  <= DATA_OUT;
          r_rx_valid <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_csn   <= 1'b1;
          r_wen   <= 1'b1;
          r_oen   <= 1'b1;
        end
      endcase
    end
  end

  // A new error on the same cycle as err_clr is kept.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_err <= '0;
    else r_err <= (err_clr ? 3'b000 : r_err) | {FRAMING_ERR, PARITY_ERR, OVERFLOW};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_baud   <= 13'd1;
      r_bit8   <= 1'b1;
      r_par_en <= 1'b0;
      r_odd    <= 1'b0;
    end else if (cfg_load && (r_state == S_IDLE) && w_empty) begin
      r_baud   <= cfg_baud;
      r_bit8   <= cfg_bit8;
      r_par_en <= cfg_par_en;
      r_odd    <= cfg_odd;
    end
  end

endmodule

// File: tb/tb_uart_core_ctrl.sv
module tb_uart_core_ctrl;

  localparam int WR_GUARD = 2;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        cfg_load;
  logic [12:0] cfg_baud;
  logic        cfg_bit8, cfg_par_en, cfg_odd;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        err_clr;
  logic [2:0]  err_status;
  logic [12:0] BAUD_VAL;
  logic        BIT8, PARITY_EN, ODD_N_EVEN;
  logic        CSN, WEN, OEN;
  logic [7:0]  DATA_IN, DATA_OUT;
  logic        TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  uart_core_ctrl #(.TX_DEPTH(4), .WR_GUARD(WR_GUARD)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .cfg_load(cfg_load), .cfg_baud(cfg_baud), .cfg_bit8(cfg_bit8),
    .cfg_par_en(cfg_par_en), .cfg_odd(cfg_odd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_clr(err_clr), .err_status(err_status),
    .BAUD_VAL(BAUD_VAL), .BIT8(BIT8), .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN),
    .CSN(CSN), .WEN(WEN), .OEN(OEN), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR),
    .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW)
  );

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++; if ({CSN, WEN, OEN} !== 3'b111) begin errors++; $display("FAIL reset_strobes got=%b exp=111", {CSN, WEN, OEN}); end
    checks++; if (DATA_IN !== 8'h00) begin errors++; $display("FAIL reset_data_in got=%h exp=00", DATA_IN); end
    checks++; if (BAUD_VAL !== 13'd1) begin errors++; $display("FAIL reset_baud got=%h exp=0001", BAUD_VAL); end
    checks++; if ({BIT8, PARITY_EN, ODD_N_EVEN} !== 3'b100) begin errors++; $display("FAIL reset_cfg got=%b exp=100", {BIT8, PARITY_EN, ODD_N_EVEN}); end
    checks++; if ({tx_ready, rx_valid} !== 2'b10) begin errors++; $display("FAIL reset_hs got=%b exp=10", {tx_ready, rx_valid}); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (err_status !== 3'b000) begin errors++; $display("FAIL reset_err got=%b exp=000", err_status); end
  endtask

  task automatic test_tx_single();
    TXRDY = 1'b1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    checks++; if (WEN !== 1'b1) begin errors++; $display("FAIL tx1_early_wen got=%b exp=1", WEN); end
    @(negedge CLK);
    checks++; if ({CSN, WEN} !== 2'b00) begin errors++; $display("FAIL tx1_strobe got=%b exp=00", {CSN, WEN}); end
    checks++; if (DATA_IN !== 8'hA5) begin errors++; $display("FAIL tx1_data got=%h exp=a5", DATA_IN); end
    for (int c = 0; c < 1 + WR_GUARD + 2; c++) begin
      @(negedge CLK);
      checks++; if ({CSN, WEN} !== 2'b11) begin errors++; $display("FAIL tx1_after_%0d got=%b exp=11", c, {CSN, WEN}); end
    end
  endtask

  task automatic test_fifo_full();
    int nw;
    int last;
    logic exp_rdy;
    TXRDY = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tx_data = 8'(k); tx_valid = 1'b1;
      exp_rdy = (k <= 4);
      checks++; if (tx_ready !== exp_rdy) begin errors++; $display("FAIL fifo_ready_b%0d got=%b exp=%b", k, tx_ready, exp_rdy); end
      @(negedge CLK);
    end
    tx_valid = 1'b0;
    checks++; if (WEN !== 1'b1) begin errors++; $display("FAIL fifo_held_wen got=%b exp=1", WEN); end
    TXRDY = 1'b1;
    nw = 0; last = -100;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (WEN === 1'b0) begin
        checks++; if (DATA_IN !== 8'(nw + 1)) begin errors++; $display("FAIL fifo_order_%0d got=%h exp=%h", nw, DATA_IN, 8'(nw + 1)); end
        if (nw > 0) begin
          checks++; if (c - last < WR_GUARD + 1) begin errors++; $display("FAIL fifo_gap_%0d got=%0d exp>=%0d", nw, c - last, WR_GUARD + 1); end
        end
        last = c; nw++;
      end
    end
    checks++; if (nw !== 4) begin errors++; $display("FAIL fifo_write_count got=%0d exp=4", nw); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL fifo_drained_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_rx_priority();
    TXRDY = 1'b0;
    tx_data = 8'h77; tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    @(negedge CLK);
    DATA_OUT = 8'h3C; RXRDY = 1'b1; TXRDY = 1'b1;
    @(negedge CLK);
    checks++; if ({CSN, OEN, WEN} !== 3'b001) begin errors++; $display("FAIL rxp_rd1 got=%b exp=001", {CSN, OEN, WEN}); end
    RXRDY = 1'b0;
    @(negedge CLK);
    checks++; if ({CSN, OEN, WEN} !== 3'b001) begin errors++; $display("FAIL rxp_rd2 got=%b exp=001", {CSN, OEN, WEN}); end
    @(negedge CLK);
    checks++; if ({OEN, WEN, rx_valid} !== 3'b111) begin errors++; $display("FAIL rxp_done got=%b exp=111", {OEN, WEN, rx_valid}); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rxp_data got=%h exp=3c", rx_data); end
    @(negedge CLK);
    checks++; if ({CSN, WEN, OEN} !== 3'b001) begin errors++; $display("FAIL rxp_then_wr got=%b exp=001", {CSN, WEN, OEN}); end
    checks++; if (DATA_IN !== 8'h77) begin errors++; $display("FAIL rxp_wr_data got=%h exp=77", DATA_IN); end
  endtask

  task automatic test_rx_backpressure();
    repeat (5) @(negedge CLK);
    DATA_OUT = 8'h5A; RXRDY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      checks++; if (OEN !== 1'b1) begin errors++; $display("FAIL rxb_blocked_%0d got=%b exp=1", c, OEN); end
    end
    checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL rxb_hold got=%b/%h exp=1/3c", rx_valid, rx_data); end
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    checks++; if ({rx_valid, OEN} !== 2'b01) begin errors++; $display("FAIL rxb_consumed got=%b exp=01", {rx_valid, OEN}); end
    @(negedge CLK);
    checks++; if (OEN !== 1'b0) begin errors++; $display("FAIL rxb_rd1 got=%b exp=0", OEN); end
    @(negedge CLK);
    checks++; if (OEN !== 1'b0) begin errors++; $display("FAIL rxb_rd2 got=%b exp=0", OEN); end
    @(negedge CLK);
    RXRDY = 1'b0;
    checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rxb_second got=%b/%h exp=1/5a", rx_valid, rx_data); end
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rxb_second_consumed got=%b exp=0", rx_valid); end
    OVERFLOW = 1'b1;
    @(negedge CLK);
    OVERFLOW = 1'b0;
    checks++; if (err_status !== 3'b001) begin errors++; $display("FAIL ovf_set got=%b exp=001", err_status); end
    repeat (3) @(negedge CLK);
    checks++; if (err_status !== 3'b001) begin errors++; $display("FAIL ovf_sticky got=%b exp=001", err_status); end
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    checks++; if (err_status !== 3'b000) begin errors++; $display("FAIL ovf_clr got=%b exp=000", err_status); end
  endtask

  task automatic test_err_same_cycle();
    FRAMING_ERR = 1'b1; err_clr = 1'b1;
    @(negedge CLK);
    FRAMING_ERR = 1'b0;
    checks++; if (err_status !== 3'b100) begin errors++; $display("FAIL err_set_wins got=%b exp=100", err_status); end
    @(negedge CLK);
    err_clr = 1'b0;
    checks++; if (err_status !== 3'b000) begin errors++; $display("FAIL err_clr_alone got=%b exp=000", err_status); end
    PARITY_ERR = 1'b1;
    @(negedge CLK);
    PARITY_ERR = 1'b0;
    checks++; if (err_status !== 3'b010) begin errors++; $display("FAIL err_parity got=%b exp=010", err_status); end
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    checks++; if (err_status !== 3'b000) begin errors++; $display("FAIL err_parity_clr got=%b exp=000", err_status); end
  endtask

  task automatic test_cfg_and_reset();
    bit found;
    cfg_baud = 13'h145; cfg_bit8 = 1'b0; cfg_par_en = 1'b1; cfg_odd = 1'b1; cfg_load = 1'b1;
    @(negedge CLK);
    cfg_load = 1'b0;
    checks++; if (BAUD_VAL !== 13'h145) begin errors++; $display("FAIL cfg_baud got=%h exp=0145", BAUD_VAL); end
    checks++; if ({BIT8, PARITY_EN, ODD_N_EVEN} !== 3'b011) begin errors++; $display("FAIL cfg_bits got=%b exp=011", {BIT8, PARITY_EN, ODD_N_EVEN}); end
    TXRDY = 1'b0;
    tx_data = 8'h99; tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    cfg_baud = 13'h0AA; cfg_bit8 = 1'b1; cfg_par_en = 1'b0; cfg_odd = 1'b0; cfg_load = 1'b1;
    @(negedge CLK);
    cfg_load = 1'b0;
    checks++; if (BAUD_VAL !== 13'h145) begin errors++; $display("FAIL cfg_ignored_baud got=%h exp=0145", BAUD_VAL); end
    checks++; if ({BIT8, PARITY_EN, ODD_N_EVEN} !== 3'b011) begin errors++; $display("FAIL cfg_ignored_bits got=%b exp=011", {BIT8, PARITY_EN, ODD_N_EVEN}); end
    TXRDY = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge CLK);
      if (WEN === 1'b0) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_wr_reached got=%b exp=1", found); end
    RESET_N = 1'b0;
    #1;
    checks++; if ({CSN, WEN, OEN} !== 3'b111) begin errors++; $display("FAIL rst_async_strobes got=%b exp=111", {CSN, WEN, OEN}); end
    checks++; if (BAUD_VAL !== 13'd1) begin errors++; $display("FAIL rst_async_baud got=%h exp=0001", BAUD_VAL); end
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++; if (WEN !== 1'b1) begin errors++; $display("FAIL rst_fifo_discard_%0d got=%b exp=1", c, WEN); end
    end
    checks++; if (DATA_IN !== 8'h00) begin errors++; $display("FAIL rst_data_in got=%h exp=00", DATA_IN); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RESET_N = 1'b0; cfg_load = 1'b0; cfg_baud = '0; cfg_bit8 = 1'b0; cfg_par_en = 1'b0; cfg_odd = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0; DATA_OUT = '0;
    TXRDY = 1'b0; RXRDY = 1'b0; PARITY_ERR = 1'b0; FRAMING_ERR = 1'b0; OVERFLOW = 1'b0;
    test_reset();
    test_tx_single();
    test_fifo_full();
    test_rx_priority();
    test_rx_backpressure();
    test_err_same_cycle();
    test_cfg_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
